// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the PC, issues 1-cycle ROM reads and buffers returned words in a 2-entry skid FIFO
module imem_fetch_ctrl #(
  parameter int N = 31,
  parameter int ADDR_BITS = 10,
  parameter logic [N:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_en_i,
  input  logic                 redirect_valid_i,
  input  logic [N:0]           redirect_pc_i,
  output logic                 rom_en_o,
  output logic [ADDR_BITS-1:0] rom_addr_o,
  input  logic [N:0]           rom_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [N:0]           out_instr_o,
  output logic [N:0]           out_pc_o
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [N:0] pc_q, pc_d, tag_q;
  logic [N:0] instr_q [2];
  logic [N:0] ipc_q [2];
  logic inflight_q, rd_q, wr_q, xfer, push;
  logic [1:0] count_q, count_d, occ;
  always_comb begin
    occ = count_q + {1'b0, inflight_q};
    out_valid_o = !rst && count_q != 2'd0;
    xfer = out_valid_o && out_ready_i;
    push = inflight_q && !redirect_valid_i;
    rom_en_o = !rst && state_q == RUN && fetch_en_i && !redirect_valid_i && (occ < 2'd2 || (occ == 2'd2 && xfer));
    state_d = redirect_valid_i ? state_q : (fetch_en_i ? RUN : IDLE);
    pc_d = redirect_valid_i ? (redirect_pc_i & ~(N+1)'(3)) : rom_en_o ? pc_q + (N+1)'(4) : pc_q;
    count_d = redirect_valid_i ? 2'd0 : count_q + {1'b0, push} - {1'b0, xfer};
    rom_addr_o = pc_q[ADDR_BITS+1:2];
    out_instr_o = out_valid_o ? instr_q[rd_q] : '0;
    out_pc_o = out_valid_o ? ipc_q[rd_q] : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      tag_q <= '0;
      inflight_q <= 1'b0;
      count_q <= 2'd0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      inflight_q <= rom_en_o;
      count_q <= count_d;
      if (rom_en_o) tag_q <= pc_q;
      rd_q <= redirect_valid_i ? 1'b0 : rd_q ^ xfer;
      wr_q <= redirect_valid_i ? 1'b0 : wr_q ^ push;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_q] <= rom_data_i;
      ipc_q[wr_q] <= tag_q;
    end
  end
  // issue throttling guarantees the FIFO never has to absorb a third word
  assert property (@(posedge clk) disable iff (rst) occ <= 2'd2);
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed + random stimulus against a queue-based model of issued-but-unconsumed fetches
module tb_imem_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, redirect_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0, rom_data = '0, out_instr, out_pc;
  logic rom_en, out_valid;
  logic [9:0] rom_addr;
  int vectors = 0, errors = 0, cyc = 0;
  typedef struct {logic [31:0] pc; int vis;} item_t;
  item_t q[$];
  logic [31:0] m_pc = RESET_PC;
  bit m_run = 1'b0;

  imem_fetch_ctrl #(.N(31), .ADDR_BITS(10), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .fetch_en_i(fetch_en), .redirect_valid_i(redirect_valid),
    .redirect_pc_i(redirect_pc), .rom_en_o(rom_en), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_instr_o(out_instr), .out_pc_o(out_pc)
  );

  always #5 clk = ~clk;
  // ROM word k holds k; unread cycles return junk so a stray push is visible
  always @(posedge clk) rom_data <= rom_en ? {22'b0, rom_addr} : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input bit r, input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit ev, er;
    logic [31:0] epc;
    rst = r; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
    @(negedge clk);
    ev = !r && q.size() > 0 && q[0].vis <= cyc;
    er = !r && m_run && fe && !rv && (q.size() < 2 || (q.size() == 2 && ev && rdy));
    epc = ev ? q[0].pc : 32'h0;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_pc", out_pc, epc);
    chk("out_instr", out_instr, ev ? {22'b0, epc[11:2]} : 32'h0);
    chk("rom_en", 32'(rom_en), 32'(er));
    if (er) chk("rom_addr", 32'(rom_addr), 32'(m_pc[11:2]));
    @(posedge clk);
    if (r) begin
      q.delete();
      m_pc = RESET_PC;
      m_run = 1'b0;
    end else begin
      if (ev && rdy) void'(q.pop_front());
      if (rv) begin
        q.delete();
        m_pc = {rpc[31:2], 2'b00};
      end
      if (er) begin
        q.push_back('{m_pc, cyc + 2});
        m_pc = m_pc + 32'd4;
      end
      if (!rv) m_run = fe;
    end
    cyc++;
    #1;
  endtask

  initial begin
    #1;
    repeat (2) step(1, 0, 0, 0, 0);
    repeat (10) step(0, 1, 0, 0, 1);
    repeat (5) step(0, 1, 0, 0, 0);
    repeat (8) step(0, 1, 0, 0, 1);
    repeat (4) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 32'h100, 0);
    repeat (6) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h102, 1);
    repeat (5) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'h40, 1);
    step(0, 1, 1, 32'h80, 1);
    repeat (5) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'hFF8, 1);
    repeat (6) step(0, 1, 0, 0, 1);
    step(0, 1, 1, 32'hFFFFFFF8, 1);
    repeat (6) step(0, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    repeat (6) step(0, 1, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 1);
    repeat (4) step(0, 1, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 2047) << 1);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
           rpc, $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer in front of the instruction ROM (synchronous block ROM, 1-cycle read latency, word-indexed 10-bit address). It owns the PC, issues ROM reads, tracks in-flight reads, and buffers returned words in a 2-entry skid FIFO. The FIFO lets decode stall without losing data. Branch/jump redirects flush stale fetches. Sits between the instruction ROM wrapper and the decode stage.

Parameters:
N, 31, MSB index of PC and instruction (width N+1)
ADDR_BITS, 10, ROM word-address width
RESET_PC, 0, PC loaded on reset (byte address)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  synchronous reset, active-high
fetch_en  in  1  permits new ROM reads
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  N+1  new byte-address PC; bits [1:0] ignored (treated as 0)
rom_en  out  1  ROM read enable
rom_addr  out  ADDR_BITS  ROM word address = pc[ADDR_BITS+1:2]
rom_data  in  N+1  ROM output; valid the cycle after rom_en
out_valid  out  1  head of FIFO valid
out_ready  in  1  decode accepts the word (transfer = out_valid & out_ready)
out_instr  out  N+1  instruction at FIFO head
out_pc  out  N+1  byte PC of out_instr

Behaviour:
- Reset (sync, rst=1 at an edge): pc=RESET_PC, FIFO count=0, inflight=0, state=IDLE. Outputs during/after reset: out_valid=0, rom_en=0, out_instr=0, out_pc=0. ROM data arriving after reset is discarded. Reset overrides all other inputs.
- State machine:
  - IDLE: no issue. Go to RUN when fetch_en=1 and redirect_valid=0.
  - RUN: issue when allowed. Go to IDLE when fetch_en=0.
  - A redirect in either state stays in the current state.
- Issue rule, combinational: rom_en=1 iff state=RUN, fetch_en=1, redirect_valid=0, and either (count+inflight < 2) or (count+inflight == 2 and a transfer occurs this cycle). On issue, pc <= pc+4; the PC wraps modulo 2^(N+1).
- In-flight tracking:
  - inflight <= rom_en.
  - Issued pc is captured in a 1-deep tag register alongside it.
  - In the next cycle, if inflight=1, {tag_pc, rom_data} is pushed into the FIFO tail.
- FIFO: 2 entries, head drives out_instr/out_pc, out_valid = (count != 0). Push and pop in the same cycle keep count unchanged. Overflow cannot occur by construction; assert count+inflight <= 2.
- Latency: issue in cycle t, data in FIFO and out_valid=1 in cycle t+2. With out_ready held 1, throughput is 1 word/cycle after the first word.
- Redirect (redirect_valid=1):
  - FIFO count <= 0. A transfer occurring in the same cycle still counts as accepted by decode.
  - The in-flight read is killed: its data is not pushed next cycle.
  - pc <= {redirect_pc[N:2], 2'b00}; no issue this cycle.
  - The first redirected word appears on out_* no earlier than 3 cycles after the redirect cycle (issue at +1, visible at +3).
- Back-to-back redirects: the last one wins; each kills any pending read.
- fetch_en drop: no new issue. The in-flight word still lands, and the FIFO drains normally. The PC holds at the next unissued address.
- out_ready=0: the FIFO fills to 2 (count+inflight capped at 2) and rom_en stays 0. The head word is held stable while out_valid=1 and out_ready=0.
- rom_addr wraps at 2^ADDR_BITS words by truncation; no error.

Test Plan:
1. rst for 2 cycles, then fetch_en=1, out_ready=1, ROM word k = k -> rom_en from cycle 1. First out_valid two cycles after the first rom_en with out_pc=0, out_instr=0, then pc 4, 8, 12 on consecutive cycles, no gaps.
2. Streaming, then out_ready=0 for 5 cycles -> count reaches 2, rom_en=0, out_pc frozen. On release, words continue in order with no loss or duplication.
3. Redirect to 0x100 while one word is in flight and 2 are buffered -> out_valid=0 next cycle, the killed word never appears, and the next accepted word is out_pc=0x100, instr=64. Also redirect to 0x102 -> out_pc=0x100.
4. Redirect and transfer in the same cycle -> the transferred word is counted once and nothing older reappears. Two consecutive redirects (0x40 then 0x80) -> first output is pc 0x80.
5. pc=0xFFC with ADDR_BITS=10 -> rom_addr=1023, then pc=0x1000 gives rom_addr=0. Also pc=0xFFFFFFFC -> next pc=0.
6. Assert rst mid-stream with an in-flight read -> next cycle out_valid=0 and rom_en=0, and the stale rom_data is not pushed. After release, fetch restarts at RESET_PC.
